// File: rtl/arcsin_seq_poly.sv
// Sequential arcsin via odd Taylor series, Horner-evaluated in s=x^2 on one shared multiplier.
// Optional macro ARCSIN_DEGREES_EN adds a SCALE state that converts the result to degrees.
module arcsin_seq_poly #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16,
   parameter int NTERMS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] y,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SQUARE = 3'd1,
      HORNER = 3'd2,
      FINAL  = 3'd3,
`ifdef ARCSIN_DEGREES_EN
      SCALE  = 3'd4,
`endif
      DONE   = 3'd5
   } state_t;

   // pi/2 in Q61 (hex digits of pi); shifted down to FRAC_W, dropping the remainder.
   localparam logic [63:0] HALF_PI_Q61 = 64'h3243F6A8885A308D;
   localparam logic signed [DATA_W-1:0] CLAMP_RAD = DATA_W'(HALF_PI_Q61 >> (61 - FRAC_W));
   localparam logic signed [DATA_W-1:0] ONE_FX = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;

`ifdef ARCSIN_DEGREES_EN
   localparam logic [63:0] DEG_Q32 = 64'd246083499207;
   localparam logic signed [DATA_W-1:0] RAD2DEG =
      DATA_W'((DEG_Q32 + (64'd1 << (31 - FRAC_W))) >> (32 - FRAC_W));
   localparam logic signed [DATA_W-1:0] CLAMP_VAL = DATA_W'(90) << FRAC_W;
`else
   localparam logic signed [DATA_W-1:0] CLAMP_VAL = CLAMP_RAD;
`endif

   function automatic logic signed [DATA_W-1:0] coef(input logic [2:0] k);
      longint n;
      longint d;
      case (k)
         3'd0:    begin n = 1;  d = 1;    end
         3'd1:    begin n = 1;  d = 6;    end
         3'd2:    begin n = 3;  d = 40;   end
         3'd3:    begin n = 5;  d = 112;  end
         default: begin n = 35; d = 1152; end
      endcase
      return DATA_W'(((n <<< FRAC_W) + d / 2) / d);
   endfunction

   state_t                     state_q, state_d;
   logic signed [DATA_W-1:0]   a_q, a_d;
   logic signed [DATA_W-1:0]   s_q, s_d;
   logic signed [DATA_W-1:0]   acc_q, acc_d;
   logic signed [DATA_W-1:0]   y_q, y_d;
   logic                       neg_q, neg_d;
   logic                       err_q, err_d;
   logic [2:0]                 k_q, k_d;

   logic signed [DATA_W-1:0]   mul_a, mul_b, mul_r;
   logic signed [2*DATA_W-1:0] prod, prod_sh;
   logic signed [DATA_W-1:0]   x_s;
   logic signed [DATA_W-1:0]   mag, res;
   logic                       accept;
   logic                       unused_hi;

   assign x_s       = x;
   assign in_ready  = (state_q == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign y         = y_q;
   assign err       = err_q;

   // Single shared multiplier; products truncate toward minus infinity.
   assign prod      = mul_a * mul_b;
   assign prod_sh   = prod >>> FRAC_W;
   assign mul_r     = prod_sh[DATA_W-1:0];
   assign unused_hi = ^prod_sh[2*DATA_W-1:DATA_W];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      s_d     = s_q;
      acc_d   = acc_q;
      y_d     = y_q;
      neg_d   = neg_q;
      err_d   = err_q;
      k_d     = k_q;
      mul_a   = '0;
      mul_b   = '0;
      mag     = '0;
      res     = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = x_s[DATA_W-1] ? -x_s : x_s;
               neg_d   = x_s[DATA_W-1];
               err_d   = (x_s > ONE_FX) || (x_s < -ONE_FX);
               state_d = SQUARE;
            end
         end
         SQUARE: begin
            mul_a   = a_q;
            mul_b   = a_q;
            s_d     = mul_r;
            acc_d   = coef(3'(NTERMS - 1));
            k_d     = 3'(NTERMS - 2);
            state_d = HORNER;
         end
         HORNER: begin
            mul_a = acc_q;
            mul_b = s_q;
            acc_d = mul_r + coef(k_q);
            if (k_q == 3'd0) begin
               state_d = FINAL;
            end else begin
               k_d = k_q - 3'd1;
            end
         end
         FINAL: begin
            mul_a = acc_q;
            mul_b = a_q;
            mag   = err_q ? CLAMP_VAL : mul_r;
            // Sign applied to the magnitude so negative inputs mirror exactly.
            res   = neg_q ? -mag : mag;
            acc_d = res;
`ifdef ARCSIN_DEGREES_EN
            state_d = SCALE;
`else
            y_d     = res;
            state_d = DONE;
`endif
         end
`ifdef ARCSIN_DEGREES_EN
         SCALE: begin
            mul_a   = acc_q;
            mul_b   = RAD2DEG;
            // Clamped results are already in degrees.
            y_d     = err_q ? acc_q : mul_r;
            state_d = DONE;
         end
`endif
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         s_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         s_q     <= s_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
         k_q     <= k_d;
      end
   end

endmodule

// File: tb/tb_arcsin_seq_poly.sv
// Directed bench for arcsin_seq_poly (DATA_W=32, FRAC_W=16, NTERMS=4); expected values hand-derived.
module tb_arcsin_seq_poly;

`ifdef ARCSIN_DEGREES_EN
   localparam int          LAT      = 7;
   localparam logic [31:0] Y_HALF   = 32'd1965760;
   localparam logic [31:0] Y_NHALF  = -32'sd1965761;
   localparam logic [31:0] Y_ONE    = 32'd4830033;
   localparam logic [31:0] Y_CLAMP  = 32'h005A0000;
   localparam logic [31:0] Y_NCLAMP = 32'hFFA60000;
`else
   localparam int          LAT      = 6;
   localparam logic [31:0] Y_HALF   = 32'd34309;
   localparam logic [31:0] Y_NHALF  = -32'sd34309;
   localparam logic [31:0] Y_ONE    = 32'd84300;
   localparam logic [31:0] Y_CLAMP  = 32'h0001921F;
   localparam logic [31:0] Y_NCLAMP = 32'hFFFE6DE1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        err;

   int checks = 0;
   int passes = 0;
   int n;

   arcsin_seq_poly #(.DATA_W(32), .FRAC_W(16), .NTERMS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   // Counts edges with the accepting edge as the first; bounded.
   task automatic wait_valid(output int cnt);
      cnt = 1;
      while (!out_valid && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   // One full transaction; optionally keeps in_valid high with a decoy x while busy.
   task automatic op(input string tag, input logic [31:0] xv, input logic [31:0] ey,
                     input logic ee, input logic busy_decoy);
      int lat;
      chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      x        = xv;
      @(posedge clk);
      #1;
      if (busy_decoy) x = 32'h00030000;
      else in_valid = 1'b0;
      wait_valid(lat);
      in_valid = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'(LAT));
      chk({tag, " y"}, y, ey);
      chk({tag, " err"}, 32'(err), 32'(ee));
      @(posedge clk);
      #1;
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst y", y, 32'd0);
      chk("rst err", 32'(err), 32'd0);
      rst = 1'b0;
      #1;

      op("half_busy", 32'h00008000, Y_HALF, 1'b0, 1'b1);
      op("neg_half", 32'hFFFF8000, Y_NHALF, 1'b0, 1'b0);
      op("clamp_pos", 32'h00010001, Y_CLAMP, 1'b1, 1'b0);
      op("clamp_neg", 32'hFFFEFFFF, Y_NCLAMP, 1'b1, 1'b0);
      op("one", 32'h00010000, Y_ONE, 1'b0, 1'b0);

      // Zero with consumer stalled for 10 cycles.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x         = 32'h0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(n);
      chk("zero latency", 32'(n), 32'(LAT));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("stall out_valid", 32'(out_valid), 32'd1);
         chk("stall y", y, 32'd0);
         chk("stall in_ready", 32'(in_ready), 32'd0);
      end
      chk("stall err", 32'(err), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release in_ready", 32'(in_ready), 32'd1);
      chk("release out_valid", 32'(out_valid), 32'd0);

      // Reset during HORNER aborts the transaction.
      in_valid = 1'b1;
      x        = 32'h00008000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort in_ready in rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort in_ready", 32'(in_ready), 32'd1);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort y", y, 32'd0);
      chk("abort err", 32'(err), 32'd0);
      n = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) n++;
      end
      chk("abort no result", 32'(n), 32'd0);
      op("after_abort", 32'h0, 32'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
